// File: rtl/uabc_2024_if.sv
// Tiny Tapeout harness bus for uabc_2024: enable, dedicated inputs/outputs
// and bidirectional pins. The harness side is the master and the design is the slave.
interface uabc_2024_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/uabc_2024.sv
// Single-digit decimal counter shown on a 7-segment display. A programmable
// prescaler steps the digit up or down, and the dp bit toggles on each step.
module uabc_2024 #(
  parameter int PRESCALE_W = 24,
  parameter int CMP_SHIFT  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  uabc_2024_if.slave bus
);
  localparam int CMP_FULL_W = 8 + CMP_SHIFT;

  logic [CMP_FULL_W-1:0] cmp_full;
  logic [PRESCALE_W-1:0] cmp;
  logic [PRESCALE_W-1:0] cmp_last;
  logic [PRESCALE_W-1:0] presc_d, presc_q;
  logic [3:0]            digit_d, digit_q;
  logic                  dp_d, dp_q;
  logic                  halted;
  logic                  tick;
  logic                  dir;
  logic                  clr;
  logic [6:0]            seg;
  logic                  unused_uio;

  assign cmp_full = CMP_FULL_W'(bus.ui_in) << CMP_SHIFT;
  assign cmp      = PRESCALE_W'(cmp_full);
  assign cmp_last = cmp - PRESCALE_W'(1);

  // The >= compare lets a lowered period take effect on the very next edge
  assign halted = (bus.ui_in == 8'd0);
  assign tick   = !halted && (presc_q >= cmp_last);
  assign dir    = bus.uio_in[0];
  assign clr    = bus.uio_in[1];

  always_comb begin
    presc_d = presc_q;
    digit_d = digit_q;
    dp_d    = dp_q;
    if (bus.ena) begin
      if (clr) begin
        presc_d = '0;
        digit_d = 4'd0;
      end else if (halted) begin
        presc_d = '0;
      end else if (tick) begin
        presc_d = '0;
        dp_d    = ~dp_q;
        if (dir) begin
          digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
        end else begin
          digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
        end
      end else begin
        presc_d = presc_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      digit_q <= 4'd0;
      dp_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
      dp_q    <= dp_d;
    end
  end

  // Segment order is g..a with bit 0 = a
  always_comb begin
    seg = 7'h00;
    case (digit_q)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

  assign bus.uo_out  = {dp_q, seg};
  assign bus.uio_out = {4'b0000, digit_q};
  assign bus.uio_oe  = 8'h0F;

  assign unused_uio = &{1'b0, bus.uio_in[7:2]};
endmodule

// File: tb/tb_uabc_2024.sv
// Self-checking bench for uabc_2024: a fixed vector table, hand-written
// prescaler/halt/async-reset sequences and random traffic against a digit model.
module tb_uabc_2024;
  typedef struct {
    logic       ena;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  int   m_digit;
  int   m_cnt;
  bit   m_dp;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  vec_t vecs [24];

  uabc_2024_if bus ();

  uabc_2024 #(.PRESCALE_W(24), .CMP_SHIFT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic e, input logic [7:0] u, input logic [7:0] io,
                              input logic [7:0] euo, input logic [7:0] euio);
    vec_t v;
    v.ena = e; v.ui = u; v.uio = io; v.exp_uo = euo; v.exp_uio = euio;
    return v;
  endfunction

  // Digit model: one step per edge with the inputs that were applied at that edge
  task automatic modelStep(input logic e, input logic [7:0] u, input logic [7:0] io);
    if (e) begin
      if (io[1]) begin
        m_digit = 0;
        m_cnt   = 0;
      end else if (u == 8'd0) begin
        m_cnt = 0;
      end else if (m_cnt >= int'(u) - 1) begin
        m_cnt   = 0;
        m_dp    = !m_dp;
        m_digit = io[0] ? (m_digit + 9) % 10 : (m_digit + 1) % 10;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic modelReset();
    m_digit = 0;
    m_cnt   = 0;
    m_dp    = 1'b0;
  endtask

  function automatic logic [7:0] expUo();
    return {m_dp, seg_tab[m_digit]};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [7:0] u, input logic [7:0] io);
    bus.ena    = e;
    bus.ui_in  = u;
    bus.uio_in = io;
    @(posedge clk);
    modelStep(e, u, io);
    #1;
  endtask

  initial begin
    logic [7:0] prev_uio;
    logic [7:0] prev_uo;
    logic [7:0] held;
    logic [7:0] r_ui;
    logic [7:0] r_uio;
    logic       r_ena;
    tests = 0;
    fails = 0;
    modelReset();

    vecs[0]  = mk(1, 1, 8'h00, 8'h86, 8'h01);
    vecs[1]  = mk(1, 1, 8'h00, 8'h5B, 8'h02);
    vecs[2]  = mk(1, 1, 8'h00, 8'hCF, 8'h03);
    vecs[3]  = mk(1, 1, 8'h00, 8'h66, 8'h04);
    vecs[4]  = mk(1, 1, 8'h00, 8'hED, 8'h05);
    vecs[5]  = mk(1, 1, 8'h00, 8'h7D, 8'h06);
    vecs[6]  = mk(1, 1, 8'h00, 8'h87, 8'h07);
    vecs[7]  = mk(1, 1, 8'h00, 8'h7F, 8'h08);
    vecs[8]  = mk(1, 1, 8'h00, 8'hEF, 8'h09);
    vecs[9]  = mk(1, 1, 8'h00, 8'h3F, 8'h00);
    vecs[10] = mk(1, 1, 8'h01, 8'hEF, 8'h09);
    vecs[11] = mk(1, 1, 8'h01, 8'h7F, 8'h08);
    vecs[12] = mk(0, 1, 8'h01, 8'h7F, 8'h08);
    vecs[13] = mk(0, 1, 8'h01, 8'h7F, 8'h08);
    vecs[14] = mk(1, 1, 8'h00, 8'hEF, 8'h09);
    vecs[15] = mk(1, 1, 8'h02, 8'hBF, 8'h00);
    vecs[16] = mk(1, 1, 8'h02, 8'hBF, 8'h00);
    vecs[17] = mk(1, 0, 8'h00, 8'hBF, 8'h00);
    vecs[18] = mk(1, 2, 8'h00, 8'hBF, 8'h00);
    vecs[19] = mk(1, 2, 8'h00, 8'h06, 8'h01);
    vecs[20] = mk(1, 1, 8'h03, 8'h06, 8'h00);
    vecs[21] = mk(1, 5, 8'hFC, 8'h06, 8'h00);
    vecs[22] = mk(1, 5, 8'h00, 8'h06, 8'h00);
    vecs[23] = mk(1, 2, 8'h00, 8'h86, 8'h01);
    // Record 20 is a clear coinciding with a due tick: dp must keep its value
    vecs[20].exp_uo = 8'h3F;
    vecs[21].exp_uo = 8'h3F;
    vecs[22].exp_uo = 8'h3F;

    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'd0;
    bus.uio_in = 8'd0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("reset uo_out", bus.uo_out, 8'h3F);
    checkOutput("reset uio_out", bus.uio_out, 8'h00);
    checkOutput("reset uio_oe", bus.uio_oe, 8'h0F);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].ena, vecs[i].ui, vecs[i].uio);
      checkOutput($sformatf("vec%0d uo_out", i), bus.uo_out, vecs[i].exp_uo);
      checkOutput($sformatf("vec%0d uio_out", i), bus.uio_out, vecs[i].exp_uio);
    end

    // Period 4: the digit and dp change on every fourth edge only
    prev_uio = bus.uio_out;
    prev_uo  = bus.uo_out;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 8'd4, 8'h00);
      checkOutput($sformatf("presc4 step%0d", i), {7'd0, bus.uio_out != prev_uio},
                  {7'd0, (i % 4) == 3});
      checkOutput($sformatf("presc4 dp%0d", i), {7'd0, bus.uo_out[7] != prev_uo[7]},
                  {7'd0, (i % 4) == 3});
      checkOutput($sformatf("presc4 model%0d", i), bus.uo_out, expUo());
      prev_uio = bus.uio_out;
      prev_uo  = bus.uo_out;
    end

    held = bus.uio_out;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, 8'd0, 8'h00);
      checkOutput($sformatf("halt%0d uio_out", i), bus.uio_out, held);
    end

    for (int i = 0; i < 400; i++) begin
      r_ena = ($urandom_range(0, 7) != 0);
      r_ui  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      r_uio = 8'($urandom);
      r_uio[1] = ($urandom_range(0, 15) == 0);
      applyStimulus(r_ena, r_ui, r_uio);
      checkOutput($sformatf("rand%0d uo_out", i), bus.uo_out, expUo());
      checkOutput($sformatf("rand%0d uio_out", i), bus.uio_out, {4'd0, 4'(m_digit)});
    end
    checkOutput("rand uio_oe", bus.uio_oe, 8'h0F);

    // Async reset between edges must act without waiting for a clock
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'd1, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset uo_out", bus.uo_out, 8'h3F);
    checkOutput("async reset uio_out", bus.uio_out, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'd1, 8'h00);
      checkOutput($sformatf("post reset%0d uio_out", i), bus.uio_out, 8'(i + 1));
      checkOutput($sformatf("post reset%0d uo_out", i), bus.uo_out, expUo());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
